// File: rtl/reg_port_arbiter.sv
// Two-initiator front end for the register file: arbitrates the write and read channels
// independently, buffers one deferred request per port per channel, and steers read returns.
module reg_port_arbiter #(
  parameter bit PRIO_INIT = 1'b0,
  parameter bit BYPASS    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_write_en,
  input  logic [3:0]  a_write_reg,
  input  logic [31:0] a_write_value,
  input  logic        a_read_en,
  input  logic [3:0]  a_read_reg,
  output logic [31:0] a_read_value,
  output logic        a_read_valid,
  output logic        a_busy,
  input  logic        b_write_en,
  input  logic [3:0]  b_write_reg,
  input  logic [31:0] b_write_value,
  input  logic        b_read_en,
  input  logic [3:0]  b_read_reg,
  output logic [31:0] b_read_value,
  output logic        b_read_valid,
  output logic        b_busy,
  output logic        rf_write_en,
  output logic [3:0]  rf_write_reg,
  output logic [31:0] rf_write_value,
  output logic        rf_read_en,
  output logic [3:0]  rf_read_reg,
  input  logic [31:0] rf_read_value
);

  logic        aw_q, bw_q, ar_q, br_q;
  logic [3:0]  aw_reg_q, bw_reg_q, ar_reg_q, br_reg_q;
  logic [31:0] aw_val_q, bw_val_q;
  logic        rr_w_q, rr_w_d, rr_r_q, rr_r_d;
  logic        cap_aw, cap_bw, cap_ar, cap_br;
  logic        new_aw, new_bw, new_ar, new_br;
  logic        we, re, rd_owner;
  logic [3:0]  w_reg, r_reg;
  logic [31:0] w_val;
  logic        tag_vld_q, tag_q, byp_q;
  logic [31:0] byp_val_q, a_last_q, b_last_q, ret_val;

  // A request arriving while its own pending slot is full is dropped.
  assign new_aw = a_write_en & ~aw_q;
  assign new_bw = b_write_en & ~bw_q;
  assign new_ar = a_read_en & ~ar_q;
  assign new_br = b_read_en & ~br_q;

  always_comb begin
    we     = 1'b0;
    w_reg  = a_write_reg;
    w_val  = a_write_value;
    cap_aw = 1'b0;
    cap_bw = 1'b0;
    rr_w_d = rr_w_q;
    if (aw_q) begin
      we     = 1'b1;
      w_reg  = aw_reg_q;
      w_val  = aw_val_q;
      cap_bw = new_bw;
    end else if (bw_q) begin
      we     = 1'b1;
      w_reg  = bw_reg_q;
      w_val  = bw_val_q;
      cap_aw = new_aw;
    end else if (new_aw && new_bw) begin
      we     = 1'b1;
      rr_w_d = ~rr_w_q;
      if (rr_w_q) begin
        w_reg  = b_write_reg;
        w_val  = b_write_value;
        cap_aw = 1'b1;
      end else begin
        cap_bw = 1'b1;
      end
    end else if (new_aw) begin
      we = 1'b1;
    end else if (new_bw) begin
      we    = 1'b1;
      w_reg = b_write_reg;
      w_val = b_write_value;
    end
  end

  always_comb begin
    re       = 1'b0;
    r_reg    = a_read_reg;
    rd_owner = 1'b0;
    cap_ar   = 1'b0;
    cap_br   = 1'b0;
    rr_r_d   = rr_r_q;
    if (ar_q) begin
      re     = 1'b1;
      r_reg  = ar_reg_q;
      cap_br = new_br;
    end else if (br_q) begin
      re       = 1'b1;
      r_reg    = br_reg_q;
      rd_owner = 1'b1;
      cap_ar   = new_ar;
    end else if (new_ar && new_br) begin
      re     = 1'b1;
      rr_r_d = ~rr_r_q;
      if (rr_r_q) begin
        r_reg    = b_read_reg;
        rd_owner = 1'b1;
        cap_ar   = 1'b1;
      end else begin
        cap_br = 1'b1;
      end
    end else if (new_ar) begin
      re = 1'b1;
    end else if (new_br) begin
      re       = 1'b1;
      r_reg    = b_read_reg;
      rd_owner = 1'b1;
    end
  end

  assign rf_write_en    = we & ~rst;
  assign rf_write_reg   = w_reg;
  assign rf_write_value = w_val;
  assign rf_read_en     = re & ~rst;
  assign rf_read_reg    = r_reg;

  assign ret_val      = byp_q ? byp_val_q : rf_read_value;
  assign a_read_valid = tag_vld_q & ~tag_q;
  assign b_read_valid = tag_vld_q & tag_q;
  assign a_read_value = a_read_valid ? ret_val : a_last_q;
  assign b_read_value = b_read_valid ? ret_val : b_last_q;
  assign a_busy       = aw_q | ar_q;
  assign b_busy       = bw_q | br_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_q      <= 1'b0;
      bw_q      <= 1'b0;
      ar_q      <= 1'b0;
      br_q      <= 1'b0;
      rr_w_q    <= PRIO_INIT;
      rr_r_q    <= PRIO_INIT;
      tag_vld_q <= 1'b0;
      tag_q     <= 1'b0;
      byp_q     <= 1'b0;
      byp_val_q <= '0;
      a_last_q  <= '0;
      b_last_q  <= '0;
    end else begin
      // Every pending entry issues the cycle after capture, so next state is just the capture.
      aw_q      <= cap_aw;
      bw_q      <= cap_bw;
      ar_q      <= cap_ar;
      br_q      <= cap_br;
      rr_w_q    <= rr_w_d;
      rr_r_q    <= rr_r_d;
      tag_vld_q <= re;
      tag_q     <= rd_owner;
      byp_q     <= BYPASS && we && re && (w_reg == r_reg);
      byp_val_q <= w_val;
      if (cap_aw) begin
        aw_reg_q <= a_write_reg;
        aw_val_q <= a_write_value;
      end
      if (cap_bw) begin
        bw_reg_q <= b_write_reg;
        bw_val_q <= b_write_value;
      end
      if (cap_ar) ar_reg_q <= a_read_reg;
      if (cap_br) br_reg_q <= b_read_reg;
      if (a_read_valid) a_last_q <= ret_val;
      if (b_read_valid) b_last_q <= ret_val;
    end
  end

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Directed bench for reg_port_arbiter; a small register-file model sits behind each instance.
module tb_reg_port_arbiter;

  logic        clk, rst;
  logic        a_write_en, b_write_en, a_read_en, b_read_en;
  logic [3:0]  a_write_reg, b_write_reg, a_read_reg, b_read_reg;
  logic [31:0] a_write_value, b_write_value;
  logic [31:0] a_read_value, b_read_value;
  logic        a_read_valid, b_read_valid, a_busy, b_busy;
  logic        rf_write_en, rf_read_en;
  logic [3:0]  rf_write_reg, rf_read_reg;
  logic [31:0] rf_write_value, rf_read_value;
  logic [31:0] a_read_value0, b_read_value0;
  logic        a_read_valid0, b_read_valid0, a_busy0, b_busy0;
  logic        rf_write_en0, rf_read_en0;
  logic [3:0]  rf_write_reg0, rf_read_reg0;
  logic [31:0] rf_write_value0, rf_read_value0;
  logic [31:0] mem  [16];
  logic [31:0] mem0 [16];
  int          n_chk, n_fail;

  reg_port_arbiter #(.PRIO_INIT(1'b0), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst),
    .a_write_en(a_write_en), .a_write_reg(a_write_reg), .a_write_value(a_write_value),
    .a_read_en(a_read_en), .a_read_reg(a_read_reg), .a_read_value(a_read_value),
    .a_read_valid(a_read_valid), .a_busy(a_busy),
    .b_write_en(b_write_en), .b_write_reg(b_write_reg), .b_write_value(b_write_value),
    .b_read_en(b_read_en), .b_read_reg(b_read_reg), .b_read_value(b_read_value),
    .b_read_valid(b_read_valid), .b_busy(b_busy),
    .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg), .rf_write_value(rf_write_value),
    .rf_read_en(rf_read_en), .rf_read_reg(rf_read_reg), .rf_read_value(rf_read_value)
  );

  reg_port_arbiter #(.PRIO_INIT(1'b0), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .a_write_en(a_write_en), .a_write_reg(a_write_reg), .a_write_value(a_write_value),
    .a_read_en(a_read_en), .a_read_reg(a_read_reg), .a_read_value(a_read_value0),
    .a_read_valid(a_read_valid0), .a_busy(a_busy0),
    .b_write_en(b_write_en), .b_write_reg(b_write_reg), .b_write_value(b_write_value),
    .b_read_en(b_read_en), .b_read_reg(b_read_reg), .b_read_value(b_read_value0),
    .b_read_valid(b_read_valid0), .b_busy(b_busy0),
    .rf_write_en(rf_write_en0), .rf_write_reg(rf_write_reg0), .rf_write_value(rf_write_value0),
    .rf_read_en(rf_read_en0), .rf_read_reg(rf_read_reg0), .rf_read_value(rf_read_value0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: read data registered, returns the pre-write value on a same-cycle collision.
  always_ff @(posedge clk) begin
    if (rf_write_en) mem[rf_write_reg] <= rf_write_value;
    if (rf_read_en) rf_read_value <= mem[rf_read_reg];
    if (rf_write_en0) mem0[rf_write_reg0] <= rf_write_value0;
    if (rf_read_en0) rf_read_value0 <= mem0[rf_read_reg0];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_write_en = 0; a_write_reg = 0; a_write_value = 0; a_read_en = 0; a_read_reg = 0;
    b_write_en = 0; b_write_reg = 0; b_write_value = 0; b_read_en = 0; b_read_reg = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    a_write_en = 1; a_write_reg = 4'd1; a_write_value = 32'h1;
    step();
    @(negedge clk);
    n_chk++;
    if (rf_write_en !== 1'b0) begin
      n_fail++; $display("FAIL rst_we_gated: got %b want 0", rf_write_en);
    end
    step();
    idle();
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({a_busy, b_busy, a_read_valid, b_read_valid, rf_read_en} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_flags: got %b want 00000",
               {a_busy, b_busy, a_read_valid, b_read_valid, rf_read_en});
    end
    n_chk++;
    if (a_read_value !== 32'h0 || b_read_value !== 32'h0) begin
      n_fail++; $display("FAIL rst_values: got %h %h want 0 0", a_read_value, b_read_value);
    end
    step();
  endtask

  task automatic test_passthrough();
    a_write_en = 1; a_write_reg = 4'd15; a_write_value = 32'h0000_1000;
    @(negedge clk);
    n_chk++;
    if (rf_write_en !== 1'b1 || rf_write_reg !== 4'd15 || rf_write_value !== 32'h1000) begin
      n_fail++;
      $display("FAIL pt_write: got en=%b reg=%0d val=%h want 1 15 00001000",
               rf_write_en, rf_write_reg, rf_write_value);
    end
    step(); idle();
    step();
    a_read_en = 1; a_read_reg = 4'd15;
    @(negedge clk);
    n_chk++;
    if (rf_read_en !== 1'b1 || rf_read_reg !== 4'd15) begin
      n_fail++; $display("FAIL pt_read_issue: got en=%b reg=%0d want 1 15", rf_read_en, rf_read_reg);
    end
    step(); idle();
    @(negedge clk);
    n_chk++;
    if (a_read_valid !== 1'b1 || a_read_value !== 32'h1000 || b_read_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pt_return: got av=%b aval=%h bv=%b want 1 00001000 0",
               a_read_valid, a_read_value, b_read_valid);
    end
    step();
    @(negedge clk);
    n_chk++;
    if (a_read_valid !== 1'b0 || a_read_value !== 32'h1000) begin
      n_fail++; $display("FAIL pt_hold: got av=%b aval=%h want 0 00001000", a_read_valid, a_read_value);
    end
    step();
  endtask

  task automatic test_write_conflict();
    a_write_en = 1; a_write_reg = 4'd1; a_write_value = 32'h11;
    b_write_en = 1; b_write_reg = 4'd2; b_write_value = 32'h22;
    @(negedge clk);
    n_chk++;
    if (rf_write_en !== 1'b1 || rf_write_reg !== 4'd1 || rf_write_value !== 32'h11 || b_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wc_first: got en=%b reg=%0d val=%h bbusy=%b want 1 1 11 0",
               rf_write_en, rf_write_reg, rf_write_value, b_busy);
    end
    step(); idle();
    @(negedge clk);
    n_chk++;
    if (rf_write_en !== 1'b1 || rf_write_reg !== 4'd2 || rf_write_value !== 32'h22 ||
        b_busy !== 1'b1 || a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wc_deferred: got en=%b reg=%0d val=%h abusy=%b bbusy=%b want 1 2 22 0 1",
               rf_write_en, rf_write_reg, rf_write_value, a_busy, b_busy);
    end
    step();
    @(negedge clk);
    n_chk++;
    if (rf_write_en !== 1'b0 || b_busy !== 1'b0) begin
      n_fail++; $display("FAIL wc_drained: got en=%b bbusy=%b want 0 0", rf_write_en, b_busy);
    end
    step();
    a_write_en = 1; a_write_reg = 4'd5; a_write_value = 32'h55;
    b_write_en = 1; b_write_reg = 4'd6; b_write_value = 32'h66;
    @(negedge clk);
    n_chk++;
    if (rf_write_reg !== 4'd6 || rf_write_value !== 32'h66) begin
      n_fail++; $display("FAIL wc_rr_b_first: got reg=%0d val=%h want 6 66", rf_write_reg, rf_write_value);
    end
    step(); idle();
    @(negedge clk);
    n_chk++;
    if (rf_write_en !== 1'b1 || rf_write_reg !== 4'd5 || a_busy !== 1'b1 || b_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wc_rr_a_deferred: got en=%b reg=%0d abusy=%b bbusy=%b want 1 5 1 0",
               rf_write_en, rf_write_reg, a_busy, b_busy);
    end
    step();
  endtask

  task automatic test_read_conflict();
    a_read_en = 1; a_read_reg = 4'd1;
    b_read_en = 1; b_read_reg = 4'd2;
    @(negedge clk);
    n_chk++;
    if (rf_read_en !== 1'b1 || rf_read_reg !== 4'd1) begin
      n_fail++; $display("FAIL rc_first: got en=%b reg=%0d want 1 1", rf_read_en, rf_read_reg);
    end
    step(); idle();
    @(negedge clk);
    n_chk++;
    if (a_read_valid !== 1'b1 || a_read_value !== 32'h11 || b_read_valid !== 1'b0 ||
        rf_read_reg !== 4'd2 || b_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rc_a_return: got av=%b aval=%h bv=%b rreg=%0d bbusy=%b want 1 11 0 2 1",
               a_read_valid, a_read_value, b_read_valid, rf_read_reg, b_busy);
    end
    step();
    @(negedge clk);
    n_chk++;
    if (b_read_valid !== 1'b1 || b_read_value !== 32'h22 || a_read_valid !== 1'b0 ||
        a_read_value !== 32'h11) begin
      n_fail++;
      $display("FAIL rc_b_return: got bv=%b bval=%h av=%b aval=%h want 1 22 0 11",
               b_read_valid, b_read_value, a_read_valid, a_read_value);
    end
    step();
  endtask

  task automatic test_bypass();
    a_write_en = 1; a_write_reg = 4'd3; a_write_value = 32'h33;
    step(); idle();
    a_write_en = 1; a_write_reg = 4'd3; a_write_value = 32'hDEAD_BEEF;
    b_read_en = 1; b_read_reg = 4'd3;
    step(); idle();
    @(negedge clk);
    n_chk++;
    if (b_read_valid !== 1'b1 || b_read_value !== 32'hDEAD_BEEF || a_read_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL byp_on: got bv=%b bval=%h av=%b want 1 deadbeef 0",
               b_read_valid, b_read_value, a_read_valid);
    end
    n_chk++;
    if (b_read_valid0 !== 1'b1 || b_read_value0 !== 32'h33) begin
      n_fail++; $display("FAIL byp_off: got bv=%b bval=%h want 1 00000033", b_read_valid0, b_read_value0);
    end
    step();
  endtask

  task automatic test_busy_violation();
    a_write_en = 1; a_write_reg = 4'd4; a_write_value = 32'h40;
    step(); idle();
    a_write_en = 1; a_write_reg = 4'd7; a_write_value = 32'h77;
    b_write_en = 1; b_write_reg = 4'd8; b_write_value = 32'h88;
    step(); idle();
    b_write_en = 1; b_write_reg = 4'd4; b_write_value = 32'h44;
    @(negedge clk);
    n_chk++;
    if (b_busy !== 1'b1 || rf_write_reg !== 4'd8 || rf_write_value !== 32'h88) begin
      n_fail++;
      $display("FAIL bv_pending: got bbusy=%b reg=%0d val=%h want 1 8 88", b_busy, rf_write_reg,
               rf_write_value);
    end
    step(); idle();
    @(negedge clk);
    n_chk++;
    if (rf_write_en !== 1'b0 || b_busy !== 1'b0) begin
      n_fail++; $display("FAIL bv_dropped: got en=%b bbusy=%b want 0 0", rf_write_en, b_busy);
    end
    step();
    a_read_en = 1; a_read_reg = 4'd4;
    step(); idle();
    @(negedge clk);
    n_chk++;
    if (a_read_valid !== 1'b1 || a_read_value !== 32'h40) begin
      n_fail++; $display("FAIL bv_r4: got av=%b aval=%h want 1 00000040", a_read_valid, a_read_value);
    end
    step();
  endtask

  task automatic test_reset_mid();
    // rr_w points at B here; one conflict swings it back to A.
    a_write_en = 1; a_write_reg = 4'd10; a_write_value = 32'hA0;
    b_write_en = 1; b_write_reg = 4'd11; b_write_value = 32'hB0;
    step(); idle();
    step();
    a_write_en = 1; a_write_reg = 4'd9; a_write_value = 32'h99;
    b_write_en = 1; b_write_reg = 4'd2; b_write_value = 32'hBAD;
    a_read_en = 1; a_read_reg = 4'd1;
    @(negedge clk);
    n_chk++;
    if (rf_write_reg !== 4'd9 || rf_read_en !== 1'b1) begin
      n_fail++; $display("FAIL rm_setup: got wreg=%0d ren=%b want 9 1", rf_write_reg, rf_read_en);
    end
    step(); idle();
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (rf_write_en !== 1'b0 || rf_read_en !== 1'b0) begin
      n_fail++; $display("FAIL rm_gated: got we=%b re=%b want 0 0", rf_write_en, rf_read_en);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (rf_write_en !== 1'b0 || b_busy !== 1'b0 || a_read_valid !== 1'b0 || b_read_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_after: got we=%b bbusy=%b av=%b bv=%b want 0 0 0 0",
               rf_write_en, b_busy, a_read_valid, b_read_valid);
    end
    step();
    a_read_en = 1; a_read_reg = 4'd2;
    step(); idle();
    @(negedge clk);
    n_chk++;
    if (a_read_valid !== 1'b1 || a_read_value !== 32'h22) begin
      n_fail++; $display("FAIL rm_r2: got av=%b aval=%h want 1 00000022", a_read_valid, a_read_value);
    end
    step();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_passthrough();
    test_write_conflict();
    test_read_conflict();
    test_bypass();
    test_busy_violation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_port_arbiter.md
Name: reg_port_arbiter

Overview:
- Responder-side block for the register-file request port that execution units such as branch drive: write_en/write_reg/write_value for writes, and read_en/read_reg/read_value for reads.
- Accepts requests from two initiator units (port A, port B) and serialises them onto the single write channel and single read channel of register_file.
- Routes each read result back to the unit that issued the read.
- Adds stall (busy), read-valid and same-cycle write-to-read bypass, so two units can share one register file without corrupting each other.

Parameters:
PRIO_INIT, 0, initial round-robin winner after reset (0 = port A, 1 = port B)
BYPASS, 1, 1 = a read issued in the same cycle as a write to the same register returns the write value

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous active-high reset
a_write_en  input  1  port A write request
a_write_reg  input  4  port A write register index
a_write_value  input  32  port A write data
a_read_en  input  1  port A read request
a_read_reg  input  4  port A read register index
a_read_value  output  32  port A read data
a_read_valid  output  1  port A read data valid strobe
a_busy  output  1  port A has a deferred request; new A requests must not be issued
b_write_en, b_write_reg, b_write_value, b_read_en, b_read_reg, b_read_value, b_read_valid, b_busy  same as port A, for port B
rf_write_en  output  1  write enable to register_file
rf_write_reg  output  4  write index to register_file
rf_write_value  output  32  write data to register_file
rf_read_en  output  1  read enable to register_file
rf_read_reg  output  4  read index to register_file
rf_read_value  input  32  register_file read data, valid one cycle after rf_read_en

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- Reset values: pending buffers empty; busy=0; read_valid=0; read_value=0; round-robin pointers=PRIO_INIT; return tag cleared. rf_write_en=0 and rf_read_en=0 in every cycle rst is high.
- Write and read channels are arbitrated independently, in the same cycle.
- Per channel, each port has a 1-entry pending buffer (reg index, plus value for writes).
- Issue priority per channel, evaluated combinationally each cycle:
  1. A non-empty pending buffer is issued first. Both pending buffers can never be full on the same channel.
  2. Otherwise, a single new request is issued directly in the same cycle (zero added latency).
  3. Otherwise, when both ports request, the port selected by the channel's round-robin pointer is issued. The loser's request is captured into its pending buffer at the posedge, and the loser's busy goes high from the next cycle.
- Round-robin pointer: toggles to the non-winner after every cycle in which a conflict was resolved. It is unchanged otherwise.
- When a new request and the other port's pending entry are both present, the pending entry issues. The new request is captured into its own pending buffer.
- busy(X) = OR of X's pending write and pending read buffers. A pending entry drains in exactly one cycle.
- A new request from port X on a channel where X's pending buffer is full is ignored: it is not issued and not buffered. Existing state is unchanged.
- Read return:
  - A 1-bit tag records which port owned rf_read_en at posedge T.
  - In cycle T+1, that port's read_value = rf_read_value (combinational pass-through) and its read_valid=1. The other port's read_valid=0.
  - Uncontended read latency is 1 cycle; a deferred read takes 2 cycles.
  - Outside valid cycles, read_value holds the last returned value.
- Bypass (BYPASS=1): if rf_write_en and rf_read_en issue in the same cycle with rf_write_reg == rf_read_reg, the arbiter saves rf_write_value. The next-cycle read return uses the saved value instead of rf_read_value. This applies even when the two requests come from different ports. With BYPASS=0, rf_read_value is always passed through.
- Reset mid-operation: pending entries are discarded, no deferred request is ever issued, and any in-flight read return is suppressed (read_valid=0 in the cycle after rst).
- Width rules: indices and data pass through unmodified. No sign or width conversion.

Test Plan:
- Uncontended pass-through: A writes R15=0x00001000 at cycle 0 → rf_write_en=1 in cycle 0. A reads R15 at cycle 2 → rf_read_en in cycle 2; in cycle 3 a_read_valid=1 and a_read_value=0x00001000. b_read_valid stays 0 throughout.
- Write conflict, PRIO_INIT=0: A writes R1=0x11 and B writes R2=0x22 in cycle 0 → A issued in cycle 0; B issued in cycle 1; b_busy=1 in cycle 1 only. A second simultaneous conflict then issues B first and sets a_busy.
- Read conflict: A reads R1 and B reads R2 in the same cycle → a_read_valid with 0x11 one cycle later; b_read_valid with 0x22 the following cycle. Never both valid in the same cycle.
- Bypass: A writes R3=0xDEADBEEF while B reads R3 in the same cycle → next cycle b_read_valid=1 and b_read_value=0xDEADBEEF, even though the register file returns the old R3 value. With BYPASS=0 the old value is returned.
- Busy violation: while b_busy=1, B issues a write R4=0x44 → not issued and not buffered; reading R4 afterwards returns its prior value.
- Reset mid-pending: create a deferred B write, then assert rst in the next cycle → rf_write_en=0 in that cycle and afterwards; b_busy=0 after reset; R2 unchanged; no read_valid in the cycle after rst.
